dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port 2Kx32 data-memory RAM between two requesters: the processor pipeline and a host/debug port used for loading and dumping data memory during test.
- Sits between the pipeline's data-memory interface and the data-memory RAM macro.
- The pipeline has priority. A starvation counter forces a host slot and stalls the pipeline for exactly that slot.
- Read data returns one cycle after the grant, tagged to the requester that issued the read.

Parameters:
- ADDR_W, 11, RAM address width (2K words).
- DATA_W, 32, RAM data width.
- STARVE_MAX, 8, consecutive cycles a pending host request may lose arbitration before a forced host slot; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- p_req  in  1  pipeline memory access this cycle.
- p_we  in  1  pipeline write (1) / read (0).
- p_addr  in  ADDR_W  pipeline word address.
- p_wdata  in  DATA_W  pipeline write data.
- p_stall  out  1  pipeline must hold its access and retry next cycle.
- p_rvalid  out  1  p_rdata valid (pipeline read issued previous cycle).
- p_rdata  out  DATA_W  read data to pipeline.
- h_req  in  1  host access request; held until granted.
- h_we  in  1  host write (1) / read (0).
- h_lock  in  1  host requests exclusive ownership (burst).
- h_addr  in  ADDR_W  host word address.
- h_wdata  in  DATA_W  host write data.
- h_gnt  out  1  host access performed this cycle.
- h_rvalid  out  1  h_rdata valid.
- h_rdata  out  DATA_W  read data to host.
- ram_cen  out  1  RAM chip enable, active low.
- ram_wen  out  1  RAM write enable, active low.
- ram_oen  out  1  RAM output enable, active low.
- ram_a  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data, valid the cycle after the read edge.

Behaviour:
- Reset values:
  - State machine in PIPE.
  - Starvation counter 0.
  - Read-owner register NONE.
  - Outputs: p_stall=0, h_gnt=0, p_rvalid=0, h_rvalid=0, ram_cen=0, ram_wen=1, ram_oen=1, ram_a=0, ram_d=0.
- Grant decision is combinational from the current state and requests. RAM controls are driven combinationally from the winner. ram_wen=0 only for a granted write.
- States:
  - PIPE:
    - Winner is the pipeline if p_req, otherwise the host if h_req.
    - Counter increments when h_req is set and the host loses; it clears when the host wins or h_req=0.
    - If the counter reaches STARVE_MAX, next state is FORCE.
    - If the host is granted with h_lock=1, next state is LOCK.
  - FORCE:
    - Host wins unconditionally; if p_req is set, p_stall=1.
    - Counter clears.
    - Next state is LOCK if h_lock, otherwise PIPE.
    - If h_req has dropped, nothing is granted and the state returns to PIPE.
  - LOCK:
    - Host wins every cycle; p_stall=p_req.
    - Exit to PIPE on the first cycle with h_lock=0. That cycle is still granted to the host if h_req is set.
- p_stall:
  - PIPE: p_stall=0, except when p_req and the host wins.
  - The pipeline never loses in PIPE, so p_stall=1 only in FORCE or LOCK with p_req set.
- Read return:
  - The owner of a granted read (P or H) is registered; NONE on writes or idle.
  - Next cycle: p_rvalid=1 if the owner is P, h_rvalid=1 if the owner is H.
  - ram_q is routed to the matching *_rdata. The non-owner *_rdata holds its last value.
- Simultaneous p_req and h_req in PIPE below threshold: the pipeline wins, h_gnt=0, counter+1.
- Write-then-read to the same address on consecutive cycles returns the new data. This follows from RAM write-first behaviour; no bypass is inside this block.
- Reset mid-operation: a pending read return is dropped (rvalid=0 the next cycle), LOCK is exited, and the counter clears.
- The counter saturates at STARVE_MAX; it never wraps.

Decomposition:
- Shared package holds:
  - State encoding PIPE/FORCE/LOCK.
  - Owner encoding NONE/P/H.
  - ADDR_W/DATA_W defaults.
- One natural sub-module, dm_starve_cnt: the saturating starvation counter with clear and inc inputs and an at_max output.

Test Plan:
1. Reset, then pipeline read at addr 0x005 (RAM preloaded 0xDEADBEEF) → ram_oen=0, ram_a=0x005 that cycle; next cycle p_rvalid=1, p_rdata=0xDEADBEEF, h_rvalid=0.
2. Host write 0x12345678 to addr 0x7FF with p_req=0 → h_gnt=1, ram_wen=0, ram_a=0x7FF same cycle; host read next cycle → h_rdata=0x12345678 one cycle later.
3. p_req and h_req both held high continuously, STARVE_MAX=8 → h_gnt=0 for 8 cycles, then exactly one cycle with h_gnt=1 and p_stall=1, then the pipeline wins again.
4. Host granted with h_lock=1 for 5 cycles while p_req=1 → p_stall=1 for all 5 lock cycles; the first cycle after h_lock=0 returns to pipeline grant with p_stall=0.
5. Pipeline read granted, then rst=1 on the next edge → p_rvalid=0, state PIPE, counter 0, ram_wen=1.
6. Host read then pipeline read on back-to-back cycles → h_rvalid, then p_rvalid, on successive cycles, each carrying its own address's data with no cross-routing.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared encodings and default widths for the data-memory arbiter
package dm_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_PIPE  = 2'd0;
    localparam logic [1:0] ST_FORCE = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P    = 2'd1;
    localparam logic [1:0] OWN_H    = 2'd2;

endpackage

// File: rtl/dm_starve_cnt.sv
// dm_starve_cnt: saturating count of consecutive cycles the host lost arbitration
module dm_starve_cnt #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [7:0] MAX_V = 8'(MAX);

    logic [7:0] cnt;

    // at_max flags the losing cycle that brings the count up to MAX
    assign at_max = inc && (cnt >= MAX_V - 8'd1);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != MAX_V)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data-memory RAM between pipeline and host port
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_lock,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic              ram_oen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              in_pipe, p_win, h_win, cnt_inc, cnt_clr, at_max;
    logic [DATA_W-1:0] p_hold, h_hold;

    assign in_pipe = state_q == ST_PIPE;
    assign p_win   = !rst && in_pipe && p_req;
    // outside PIPE the host owns the RAM; a dropped h_req leaves it idle
    assign h_win   = !rst && h_req && (in_pipe ? !p_req : 1'b1);
    assign p_stall = !rst && p_req && !p_win;
    assign h_gnt   = h_win;

    assign cnt_inc = in_pipe && h_req && !h_win;
    assign cnt_clr = !cnt_inc;

    dm_starve_cnt #(.MAX(STARVE_MAX)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    always_comb begin
        state_d = in_pipe               ? (at_max ? ST_FORCE : (h_win && h_lock) ? ST_LOCK : ST_PIPE) :
                  state_q == ST_FORCE   ? ((h_req && h_lock) ? ST_LOCK : ST_PIPE) :
                  h_lock                ? ST_LOCK : ST_PIPE;
        owner_d = (p_win && !p_we) ? OWN_P :
                  (h_win && !h_we) ? OWN_H : OWN_NONE;
    end

    assign ram_cen = 1'b0;
    assign ram_wen = !((p_win && p_we) || (h_win && h_we));
    assign ram_oen = !((p_win && !p_we) || (h_win && !h_we));
    assign ram_a   = h_win ? h_addr : p_win ? p_addr : '0;
    assign ram_d   = h_win ? h_wdata : p_win ? p_wdata : '0;

    assign p_rvalid = owner_q == OWN_P;
    assign h_rvalid = owner_q == OWN_H;
    assign p_rdata  = p_rvalid ? ram_q : p_hold;
    assign h_rdata  = h_rvalid ? ram_q : h_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PIPE;
            owner_q <= OWN_NONE;
            p_hold  <= '0;
            h_hold  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            p_hold  <= p_rdata;
            h_hold  <= h_rdata;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of arbitration, starvation, lock and read return
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, p_stall, p_rvalid;
    logic [10:0] p_addr;
    logic [31:0] p_wdata, p_rdata;
    logic        h_req, h_we, h_lock, h_gnt, h_rvalid;
    logic [10:0] h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        ram_cen, ram_wen, ram_oen;
    logic [10:0] ram_a;
    logic [31:0] ram_d, ram_q;
    logic [31:0] mem [2048];
    int          vecs = 0;
    int          errs = 0;

    dm_arbiter #(.ADDR_W(11), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_oen(ram_oen),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // write-first single-port RAM; addr 5 is preloaded while reset is held
    always @(posedge clk) begin
        if (rst)
            mem[5] <= 32'hDEADBEEF;
        if (!ram_cen && !ram_wen) begin
            mem[ram_a] <= ram_d;
            ram_q      <= ram_d;
        end else if (!ram_cen && !ram_oen)
            ram_q <= mem[ram_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pdrv(input logic r, input logic we, input logic [10:0] a, input logic [31:0] d);
        p_req = r; p_we = we; p_addr = a; p_wdata = d;
    endtask

    task automatic hdrv(input logic r, input logic we, input logic lk, input logic [10:0] a, input logic [31:0] d);
        h_req = r; h_we = we; h_lock = lk; h_addr = a; h_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        pdrv(1, 1, 11'h123, 32'hAAAA5555);
        hdrv(1, 1, 1, 11'h456, 32'h5555AAAA);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_p_stall", 32'(p_stall), 0);
        chk("rst_h_gnt", 32'(h_gnt), 0);
        chk("rst_p_rvalid", 32'(p_rvalid), 0);
        chk("rst_h_rvalid", 32'(h_rvalid), 0);
        chk("rst_ram_ctl", {29'd0, ram_cen, ram_wen, ram_oen}, 32'b011);
        chk("rst_ram_a", 32'(ram_a), 0);
        chk("rst_ram_d", ram_d, 0);

        // 1: pipeline read of preloaded word
        @(negedge clk); rst = 1'b0;
        pdrv(1, 0, 11'h005, 0); hdrv(0, 0, 0, 0, 0); #1;
        chk("t1_oen", 32'(ram_oen), 0);
        chk("t1_ram_a", 32'(ram_a), 32'h005);
        chk("t1_stall", 32'(p_stall), 0);
        @(negedge clk); pdrv(0, 0, 0, 0); #1;
        chk("t1_p_rvalid", 32'(p_rvalid), 1);
        chk("t1_p_rdata", p_rdata, 32'hDEADBEEF);
        chk("t1_h_rvalid", 32'(h_rvalid), 0);

        // 2: host write then read back at top address
        @(negedge clk); hdrv(1, 1, 0, 11'h7FF, 32'h12345678); #1;
        chk("t2_h_gnt", 32'(h_gnt), 1);
        chk("t2_wen", 32'(ram_wen), 0);
        chk("t2_ram_a", 32'(ram_a), 32'h7FF);
        chk("t2_ram_d", ram_d, 32'h12345678);
        @(negedge clk); hdrv(1, 0, 0, 11'h7FF, 0); #1;
        chk("t2_rd_gnt", 32'(h_gnt), 1);
        chk("t2_rd_oen", 32'(ram_oen), 0);
        chk("t2_rv_after_wr", 32'(h_rvalid), 0);
        @(negedge clk); hdrv(0, 0, 0, 0, 0); #1;
        chk("t2_h_rvalid", 32'(h_rvalid), 1);
        chk("t2_h_rdata", h_rdata, 32'h12345678);
        chk("t2_p_rvalid", 32'(p_rvalid), 0);
        chk("t2_p_hold", p_rdata, 32'hDEADBEEF);

        // 3: continuous contention forces one host slot after 8 losses
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); pdrv(1, 0, 11'h005, 0); hdrv(1, 0, 0, 11'h7FF, 0); #1;
            chk($sformatf("t3_lose%0d_gnt", i), 32'(h_gnt), 0);
            chk($sformatf("t3_lose%0d_stall", i), 32'(p_stall), 0);
        end
        @(negedge clk); #1;
        chk("t3_force_gnt", 32'(h_gnt), 1);
        chk("t3_force_stall", 32'(p_stall), 1);
        chk("t3_force_a", 32'(ram_a), 32'h7FF);
        chk("t3_force_prv", 32'(p_rvalid), 1);
        chk("t3_force_prd", p_rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("t3_after_gnt", 32'(h_gnt), 0);
        chk("t3_after_stall", 32'(p_stall), 0);
        chk("t3_after_a", 32'(ram_a), 32'h005);
        chk("t3_after_hrv", 32'(h_rvalid), 1);
        chk("t3_after_prv", 32'(p_rvalid), 0);
        chk("t3_after_hrd", h_rdata, 32'h12345678);
        @(negedge clk); pdrv(0, 0, 0, 0); hdrv(0, 0, 0, 0, 0); #1;

        // 4: locked host burst stalls the pipeline
        @(negedge clk); hdrv(1, 1, 1, 11'h010, 32'h0); #1;
        chk("t4_lock_gnt", 32'(h_gnt), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pdrv(1, 0, 11'h005, 0); hdrv(1, 1, 1, 11'(16 + i + 1), 32'(i)); #1;
            chk($sformatf("t4_lock%0d_stall", i), 32'(p_stall), 1);
            chk($sformatf("t4_lock%0d_gnt", i), 32'(h_gnt), 1);
        end
        @(negedge clk); hdrv(1, 1, 0, 11'h020, 32'h0); #1;
        chk("t4_exit_gnt", 32'(h_gnt), 1);
        chk("t4_exit_stall", 32'(p_stall), 1);
        @(negedge clk); hdrv(0, 0, 0, 0, 0); #1;
        chk("t4_pipe_stall", 32'(p_stall), 0);
        chk("t4_pipe_a", 32'(ram_a), 32'h005);
        chk("t4_pipe_hgnt", 32'(h_gnt), 0);

        // 5: reset drops a pending read return and clears the counter
        @(negedge clk); pdrv(1, 0, 11'h7FF, 0); hdrv(1, 0, 0, 11'h005, 0); #1;
        chk("t5_oen", 32'(ram_oen), 0);
        @(negedge clk); rst = 1'b1; #1;
        chk("t5_rst_prv", 32'(p_rvalid), 1);
        chk("t5_rst_wen", 32'(ram_wen), 1);
        chk("t5_rst_oen", 32'(ram_oen), 1);
        chk("t5_rst_stall", 32'(p_stall), 0);
        @(negedge clk); rst = 1'b0; pdrv(0, 0, 0, 0); hdrv(0, 0, 0, 0, 0); #1;
        chk("t5_prv_dropped", 32'(p_rvalid), 0);
        chk("t5_state", 32'(dut.state_q), 32'(ST_PIPE));
        chk("t5_cnt", 32'(dut.u_cnt.cnt), 0);
        chk("t5_wen", 32'(ram_wen), 1);

        // 6: back-to-back host and pipeline reads route independently
        @(negedge clk); hdrv(1, 0, 0, 11'h005, 0); #1;
        chk("t6_h_gnt", 32'(h_gnt), 1);
        @(negedge clk); hdrv(0, 0, 0, 0, 0); pdrv(1, 0, 11'h7FF, 0); #1;
        chk("t6_h_rvalid", 32'(h_rvalid), 1);
        chk("t6_h_rdata", h_rdata, 32'hDEADBEEF);
        chk("t6_p_rvalid0", 32'(p_rvalid), 0);
        @(negedge clk); pdrv(0, 0, 0, 0); #1;
        chk("t6_p_rvalid", 32'(p_rvalid), 1);
        chk("t6_p_rdata", p_rdata, 32'h12345678);
        chk("t6_h_rvalid0", 32'(h_rvalid), 0);
        chk("t6_h_hold", h_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
